// File: rtl/wave_capture_mc.sv
// Multi-channel triggered waveform capture into a double-banked sample RAM.
// Ports: clk/reset; sample strobe, data and channel tag; trigger mode, level
// and arm; display-idle handshake; registered RAM write port (address,
// enable, offset-binary sample); read_index bank select; capturing/held.
module wave_capture_mc #(
    parameter int IN_WIDTH  = 16,
    parameter int OUT_WIDTH = 8,
    parameter int DEPTH     = 9,
    parameter int CH_BITS   = 1
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          new_sample_ready,
    input  logic signed [IN_WIDTH-1:0]    new_sample_in,
    input  logic [CH_BITS-1:0]            sample_channel,
    input  logic [1:0]                    trig_mode,
    input  logic signed [IN_WIDTH-1:0]    trig_level,
    input  logic                          arm,
    input  logic                          wave_display_idle,
    output logic [CH_BITS+DEPTH:0]        write_address,
    output logic                          write_enable,
    output logic [OUT_WIDTH-1:0]          write_sample,
    output logic                          read_index,
    output logic                          capturing,
    output logic                          held
);

    typedef enum logic [1:0] {
        ARMED,
        ACTIVE,
        WAIT,
        HOLD
    } state_t;

    localparam logic [OUT_WIDTH-1:0] MSB_MASK =
        OUT_WIDTH'(1) << (OUT_WIDTH - 1);

    state_t                       state;
    state_t                       state_n;
    logic [DEPTH-1:0]             idx;
    logic [DEPTH-1:0]             idx_n;
    logic signed [IN_WIDTH-1:0]   prev_trig;
    logic                         toggle;

    logic                         we_d;
    logic [CH_BITS+DEPTH:0]       addr_d;
    logic [OUT_WIDTH-1:0]         sample_d;

    logic                         ch0;
    logic                         last_ch;
    logic                         rise;
    logic                         fall;
    logic                         hit;
    logic                         trig;

    assign ch0     = (sample_channel == '0);
    assign last_ch = &sample_channel;
    assign rise    = (prev_trig < trig_level) &&
                     (new_sample_in >= trig_level);
    assign fall    = (prev_trig >= trig_level) &&
                     (new_sample_in < trig_level);

    always_comb begin
        hit = 1'b0;
        unique case (trig_mode)
            2'b00:   hit = rise;
            2'b01:   hit = fall;
            2'b10:   hit = 1'b1;
            default: hit = rise;
        endcase
    end

    assign trig = new_sample_ready && ch0 && hit;

    always_comb begin
        state_n  = state;
        idx_n    = idx;
        toggle   = 1'b0;
        we_d     = 1'b0;
        addr_d   = write_address;
        sample_d = write_sample;
        unique case (state)
            ARMED: begin
                // Trigger sample always lands at channel 0, index 0.
                if (trig) begin
                    we_d    = 1'b1;
                    addr_d  = {~read_index, {CH_BITS{1'b0}},
                               {DEPTH{1'b0}}};
                    state_n = ACTIVE;
                end
            end
            ACTIVE: begin
                if (new_sample_ready) begin
                    we_d   = 1'b1;
                    addr_d = {~read_index, sample_channel, idx};
                    // One index step per full channel sweep.
                    if (last_ch) begin
                        if (&idx) begin
                            idx_n   = '0;
                            state_n = WAIT;
                        end else begin
                            idx_n = idx + 1'b1;
                        end
                    end
                end
            end
            WAIT: begin
                if (wave_display_idle) begin
                    toggle  = 1'b1;
                    state_n = (trig_mode == 2'b11) ? HOLD : ARMED;
                end
            end
            default: begin
                // A trigger coinciding with arm is not captured.
                if (arm) begin
                    state_n = ARMED;
                end
            end
        endcase
        if (we_d) begin
            sample_d = new_sample_in[IN_WIDTH-1 -: OUT_WIDTH] ^ MSB_MASK;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= ARMED;
            idx        <= '0;
            prev_trig  <= '0;
            read_index <= 1'b0;
        end else begin
            state <= state_n;
            idx   <= idx_n;
            if (new_sample_ready && ch0) begin
                prev_trig <= new_sample_in;
            end
            if (toggle) begin
                read_index <= ~read_index;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            write_enable  <= 1'b0;
            write_address <= '0;
            write_sample  <= '0;
        end else begin
            write_enable  <= we_d;
            write_address <= addr_d;
            write_sample  <= sample_d;
        end
    end

    assign capturing = (state == ACTIVE);
    assign held      = (state == HOLD);

endmodule
